// File: rtl/riscv_v_pkg.sv
// Shared types and helpers for the vector pipeline control logic.
// Stage bit-vectors are carried at a fixed maximum width and sliced by users.
package riscv_v_pkg;

  localparam int MAX_STAGES = 32;

  typedef logic [MAX_STAGES-1:0] stage_vec_t;

  // Width needed to hold a stage index or a count in 0..n.
  function automatic int kw_of(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic int count_ones(input stage_vec_t v);
    int c;
    c = 0;
    for (int i = 0; i < MAX_STAGES; i++) begin
      c += int'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/riscv_v_pipe_ctrl_adv.sv
// Combinational advance chain: turns per-stage valid bits plus flush/kill requests
// into the en/flush strobes of the stage registers and the issue-side ready.
module riscv_v_pipe_ctrl_adv
  import riscv_v_pkg::*;
#(
  parameter  int NUM_STAGES = 4,
  localparam int KW         = kw_of(NUM_STAGES)
) (
  input  logic                  rst,
  input  logic [NUM_STAGES-1:0] valid,
  input  logic                  out_ready,
  input  logic                  flush_req,
  input  logic                  kill_req,
  input  logic [KW-1:0]         kill_upto,
  output logic [NUM_STAGES-1:0] stage_en,
  output logic [NUM_STAGES-1:0] stage_flush,
  output logic                  in_ready
);

  logic [NUM_STAGES-1:0] adv;
  logic [NUM_STAGES-1:0] kill_mask;

  // An empty stage can always load, so bubbles are squeezed out even under stall.
  always_comb begin
    adv = '0;
    adv[NUM_STAGES-1] = !valid[NUM_STAGES-1] | out_ready;
    for (int i = NUM_STAGES - 2; i >= 0; i--) begin
      adv[i] = !valid[i] | adv[i+1];
    end
  end

  // Reset and full flush kill everything; a partial kill covers stages 1..kill_upto,
  // which naturally saturates to a full kill when kill_upto >= NUM_STAGES.
  always_comb begin
    kill_mask = '0;
    if (rst || flush_req) begin
      kill_mask = '1;
    end else if (kill_req) begin
      for (int i = 0; i < NUM_STAGES; i++) begin
        kill_mask[i] = (i < int'(kill_upto));
      end
    end
  end

  assign stage_flush = kill_mask;
  assign stage_en    = adv & ~kill_mask;
  assign in_ready    = adv[0] & !flush_req & !kill_req & !rst;

endmodule

// File: rtl/riscv_v_pipe_ctrl.sv
// Vector pipeline control: per-stage valid tracking, occupancy and a saturating
// stall counter around the combinational advance chain.
module riscv_v_pipe_ctrl
  import riscv_v_pkg::*;
#(
  parameter  int NUM_STAGES = 4,
  parameter  int CNT_W      = 32,
  localparam int KW         = kw_of(NUM_STAGES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  out_ready,
  output logic                  out_valid,
  input  logic                  flush_req,
  input  logic                  kill_req,
  input  logic [KW-1:0]         kill_upto,
  output logic [NUM_STAGES-1:0] stage_en,
  output logic [NUM_STAGES-1:0] stage_flush,
  output logic [NUM_STAGES-1:0] stage_valid,
  output logic [KW-1:0]         occupancy,
  output logic [CNT_W-1:0]      stall_cnt
);

  logic [NUM_STAGES-1:0] vld_p0;
  logic [NUM_STAGES-1:0] vld_p1;
  logic [NUM_STAGES-1:0] src_vld;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  riscv_v_pipe_ctrl_adv #(
    .NUM_STAGES(NUM_STAGES)
  ) u_adv (
    .rst        (rst),
    .valid      (vld_p1),
    .out_ready  (out_ready),
    .flush_req  (flush_req),
    .kill_req   (kill_req),
    .kill_upto  (kill_upto),
    .stage_en   (stage_en),
    .stage_flush(stage_flush),
    .in_ready   (in_ready)
  );

  // p0: next-state valid; a killed source hands a bubble to the stage above it.
  always_comb begin
    src_vld    = '0;
    src_vld[0] = in_valid & in_ready;
    for (int i = 1; i < NUM_STAGES; i++) begin
      src_vld[i] = vld_p1[i-1] & !stage_flush[i-1];
    end
    vld_p0 = vld_p1;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (stage_flush[i]) begin
        vld_p0[i] = 1'b0;
      end else if (stage_en[i]) begin
        vld_p0[i] = src_vld[i];
      end
    end
  end

  // p1: registered stage valids, occupancy and stall statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1    <= '0;
      occupancy <= '0;
      stall_cnt <= '0;
    end else begin
      vld_p1    <= vld_p0;
      occupancy <= KW'(count_ones(stage_vec_t'(vld_p0)));
      if (in_valid && !in_ready) begin
        stall_cnt <= sat_inc(stall_cnt);
      end
    end
  end

  assign stage_valid = vld_p1;
  assign out_valid   = vld_p1[NUM_STAGES-1];

endmodule

// File: tb/tb_riscv_v_pipe_ctrl.sv
// Bench for riscv_v_pipe_ctrl: directed scenarios followed by random traffic, checked
// against a model that moves numbered instructions through an array of slots.
module tb_riscv_v_pipe_ctrl;

  localparam int N  = 4;
  localparam int CW = 3;
  localparam int KW = 3;
  localparam int SAT = (1 << CW) - 1;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic          out_ready;
  logic          out_valid;
  logic          flush_req;
  logic          kill_req;
  logic [KW-1:0] kill_upto;
  logic [N-1:0]  stage_en;
  logic [N-1:0]  stage_flush;
  logic [N-1:0]  stage_valid;
  logic [KW-1:0] occupancy;
  logic [CW-1:0] stall_cnt;

  int pipe [N];
  int next_id;
  int m_stall;
  int ncmp;
  int nfail;

  riscv_v_pipe_ctrl #(
    .NUM_STAGES(N),
    .CNT_W     (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .flush_req  (flush_req),
    .kill_req   (kill_req),
    .kill_upto  (kill_upto),
    .stage_en   (stage_en),
    .stage_flush(stage_flush),
    .stage_valid(stage_valid),
    .occupancy  (occupancy),
    .stall_cnt  (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check state and strobes mid-cycle, then advance the model.
  task automatic step(input logic r, input logic iv, input logic ordy,
                      input logic fl, input logic kl, input int k);
    logic [N-1:0] m_vld;
    logic [N-1:0] e_flush;
    logic [N-1:0] e_en;
    logic         e_inr;
    logic         open [N];
    int           nxt  [N];
    int           occ;
    int           kk;

    rst       = r;
    in_valid  = iv;
    out_ready = ordy;
    flush_req = fl;
    kill_req  = kl;
    kill_upto = KW'(k);
    @(negedge clk);

    occ = 0;
    for (int i = 0; i < N; i++) begin
      m_vld[i] = (pipe[i] != 0);
      if (pipe[i] != 0) occ++;
    end
    chk("stage_valid", 32'(stage_valid), 32'(m_vld));
    chk("occupancy", 32'(occupancy), 32'(occ));
    chk("out_valid", 32'(out_valid), 32'(pipe[N-1] != 0));
    chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));

    if (r || fl) kk = N;
    else if (kl) kk = (k > N) ? N : k;
    else kk = 0;

    // Killed slots are emptied first; survivors then move forward into freed slots.
    for (int i = 0; i < N; i++) begin
      nxt[i]     = (i < kk) ? 0 : pipe[i];
      e_flush[i] = (i < kk);
    end
    if (nxt[N-1] != 0 && ordy) nxt[N-1] = 0;
    open[N-1] = (nxt[N-1] == 0);
    for (int i = N - 2; i >= 0; i--) begin
      if (nxt[i] != 0 && nxt[i+1] == 0) begin
        nxt[i+1] = nxt[i];
        nxt[i]   = 0;
      end
      open[i] = (nxt[i] == 0);
    end
    for (int i = 0; i < N; i++) begin
      e_en[i] = open[i] && (i >= kk);
    end
    e_inr = open[0] && !r && !fl && !kl;

    chk("in_ready", 32'(in_ready), 32'(e_inr));
    chk("stage_en", 32'(stage_en), 32'(e_en));
    chk("stage_flush", 32'(stage_flush), 32'(e_flush));

    if (iv && e_inr) begin
      next_id++;
      nxt[0] = next_id;
    end
    if (r) m_stall = 0;
    else if (iv && !e_inr && m_stall < SAT) m_stall++;
    for (int i = 0; i < N; i++) begin
      pipe[i] = r ? 0 : nxt[i];
    end

    @(posedge clk);
    #1;
  endtask

  initial begin
    logic r_r, r_iv, r_or, r_fl, r_kl;
    int   r_k;

    ncmp      = 0;
    nfail     = 0;
    next_id   = 0;
    m_stall   = 0;
    for (int i = 0; i < N; i++) pipe[i] = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush_req = 1'b0;
    kill_req  = 1'b0;
    kill_upto = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset values held while rst stays high.
    step(1, 1, 1, 0, 0, 0);

    // Single instruction through an empty pipe.
    step(0, 1, 1, 0, 0, 0);
    repeat (6) step(0, 0, 1, 0, 0, 0);

    // Continuous stream under back-pressure, counter saturates, then drain.
    repeat (12) step(0, 1, 0, 0, 0, 0);
    repeat (6) step(0, 1, 1, 0, 0, 0);
    repeat (5) step(0, 0, 1, 0, 0, 0);

    // Build alternating valid pattern, then stall so bubbles collapse.
    step(0, 1, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    repeat (4) step(0, 1, 0, 0, 0, 0);

    // Partial kills on a full pipe: stalled, draining, K=0 and K beyond depth.
    step(0, 1, 0, 0, 1, 2);
    repeat (3) step(0, 1, 0, 0, 0, 0);
    step(0, 1, 1, 0, 1, 2);
    repeat (3) step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 1, 0);
    step(0, 1, 1, 0, 1, 1);
    step(0, 1, 0, 0, 1, 5);
    step(0, 0, 0, 0, 0, 0);

    // Flush colliding with an output handshake and a simultaneous kill.
    repeat (5) step(0, 1, 0, 0, 0, 0);
    step(0, 1, 1, 1, 1, 3);
    step(0, 1, 1, 0, 0, 0);

    // Reset in the middle of a stalled stream.
    repeat (6) step(0, 1, 0, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    // Random traffic with occasional kill, flush and reset.
    repeat (400) begin
      r_r  = ($urandom % 60) == 0;
      r_fl = ($urandom % 25) == 0;
      r_kl = ($urandom % 8) == 0;
      r_k  = int'($urandom % 8);
      r_iv = ($urandom % 4) != 0;
      r_or = ($urandom % 3) != 0;
      step(r_r, r_iv, r_or, r_fl, r_kl, r_k);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
